// File: rtl/button_event_scheduler_if.sv
// ---------------------------------------------------------------------------
// button_event_scheduler_if
// Event handshake between the button event scheduler and its consumer.
//   evt_valid  scheduler -> consumer  an event is being offered
//   evt_id     scheduler -> consumer  index of the offered button
//   evt_ready  consumer -> scheduler  consumer accepts the offered event
// Modports: master = scheduler side, slave = consumer side.
// ---------------------------------------------------------------------------
interface button_event_scheduler_if #(
  parameter int IDW = 2
);
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/button_event_scheduler.sv
// ---------------------------------------------------------------------------
// button_event_scheduler
// Buffers one pending event per button from the debouncer pulses and hands
// them to the consumer one at a time in round-robin order. Also produces the
// slow sample_tick that clock-enables the debouncer shift registers.
//
// Ports:
//   clk_in       system clock, rising edge
//   reset        asynchronous, active-high reset
//   pulse_in     one-cycle event pulses, bit i = button i
//   clr_overrun  synchronous clear of all overrun flags
//   sample_tick  one-cycle pulse every TICK_DIV cycles
//   pending      per-button pending flags
//   overrun      sticky per-button "pulse while already pending" flags
//   evt_bus      master side of the valid/ready event handshake
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module button_event_scheduler #(
  parameter int N_BTN    = 4,
  parameter int IDW      = 2,
  parameter int TICK_DIV = 250000
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         pulse_in,
  input  logic                     clr_overrun,
  output logic                     sample_tick,
  output logic [N_BTN-1:0]         pending,
  output logic [N_BTN-1:0]         overrun,
  button_event_scheduler_if.master evt_bus
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TICK_PRE  = CW'(TICK_DIV - 2);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [CW-1:0]    tick_cnt;
  logic [0:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic             evt_valid_q;
  logic [IDW-1:0]   evt_id_q;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             grant_fire;
  logic [N_BTN-1:0] grant_mask;
  logic [N_BTN-1:0] overrun_set;
  logic [IDW-1:0]   rr_next;

  assign evt_bus.evt_valid = evt_valid_q;
  assign evt_bus.evt_id    = evt_id_q;

  // Free-running tick divider. The tick flop is loaded one count early so
  // that it is high exactly while the counter sits at TICK_DIV-1.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);
      sample_tick <= (tick_cnt == TICK_PRE);
    end
  end

  // Round-robin search: first pending bit at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!grant_found && pending[(int'(rr_ptr) + k) % N_BTN]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(rr_ptr) + k) % N_BTN);
      end
    end
  end

  assign grant_fire  = (state == ST_IDLE) && grant_found;
  assign grant_mask  = grant_fire ? (N_BTN'(1) << grant_idx) : '0;
  // A pulse landing on the bit being granted re-arms it rather than
  // counting as an overrun, so the granted bit is excluded here.
  assign overrun_set = pulse_in & pending & ~grant_mask;
  assign rr_next     = (evt_id_q == IDW'(N_BTN - 1)) ? '0 : evt_id_q + IDW'(1);

  // Pending and overrun flags; a new set always beats a same-cycle clear.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | pulse_in;
      overrun <= clr_overrun ? overrun_set : (overrun | overrun_set);
    end
  end

  // Offer FSM: grant from IDLE, hold the offer until the consumer accepts,
  // then advance the round-robin pointer past the delivered button.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            evt_id_q    <= grant_idx;
            evt_valid_q <= 1'b1;
            state       <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_valid_q && evt_bus.evt_ready) begin
            evt_valid_q <= 1'b0;
            rr_ptr      <= rr_next;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
